// File: rtl/jtroc_snd_if_if.sv
// Sound command bus between the main-CPU side (master) and the sound-board
// command interface (slave). The slave sees the command latch, trigger and
// mute from the main CPU and the Z80 control strobes. It drives back the
// command byte, the Z80 INT line, the timer nibble, the mute level and the
// debug status.
interface jtroc_snd_if_if;
    logic [7:0] snd_latch;
    logic       snd_on;
    logic       mute;
    logic       m1_n;
    logic       iorq_n;
    logic       latch_rd;
    logic [7:0] cmd_dout;
    logic       int_n;
    logic [3:0] timer_dout;
    logic       snd_mute;
    logic [7:0] st_dout;

    modport master (
        output snd_latch, snd_on, mute, m1_n, iorq_n, latch_rd,
        input  cmd_dout, int_n, timer_dout, snd_mute, st_dout
    );

    modport slave (
        input  snd_latch, snd_on, mute, m1_n, iorq_n, latch_rd,
        output cmd_dout, int_n, timer_dout, snd_mute, st_dout
    );
endinterface

// File: rtl/jtroc_snd_if.sv
// Sound-board end of the main-CPU sound command interface.
// A rising edge on snd_on captures the command byte and pulls the Z80 INT
// line low until the Z80 acknowledges it. A free-running timer nibble is
// kept for the PSG port, and the mute request is moved into the sound domain.
// Optional feature: define JTROC_SNDIF_OVERRUN_EN to build the sticky overrun
// flag, which is reported on st_dout[3]. Without it, st_dout[3] reads 0.
module jtroc_snd_if #(
    parameter int TIMER_DIV = 1024,  // cen pulses per timer step, power of two 2..65536
    parameter int SYNC_MUTE = 1      // 1: two-flop mute synchroniser, 0: single register
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    jtroc_snd_if_if.slave   bus
);

    localparam logic [15:0] PRESC_LAST = 16'(TIMER_DIV - 1);

    logic        snd_onl_q;
    logic [7:0]  cmd_q,   cmd_d;
    logic        int_n_q, int_n_d;
    logic        pend_q,  pend_d;
    logic [15:0] presc_q, presc_d;
    logic [3:0]  timer_q, timer_d;
    logic        ovr_bit;
    logic        snd_mute_w;

    logic on_edge;
    logic ack;
    logic rd_clr;

    assign on_edge = bus.snd_on & ~snd_onl_q;
    assign ack     = cen & ~bus.m1_n & ~bus.iorq_n;
    assign rd_clr  = cen & bus.latch_rd;

    // Command, interrupt and pending next state; a new edge wins over ack and read
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cmd_d   = cmd_q;
        int_n_d = int_n_q;
        pend_d  = pend_q;
        if (on_edge) begin
            cmd_d   = bus.snd_latch;
            int_n_d = 1'b0;
            pend_d  = 1'b1;
        end else begin
            if (ack)    int_n_d = 1'b1;
            if (rd_clr) pend_d  = 1'b0;
        end
    end

    // Prescaler counts cen pulses; the nibble steps each time it wraps
    always_comb begin
        presc_d = presc_q;
        timer_d = timer_q;
        if (cen) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                timer_d = timer_q + 4'd1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    // State registers for edge detect, command, interrupt, pending and timer
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            snd_onl_q <= 1'b0;
            cmd_q     <= '0;
            int_n_q   <= 1'b1;
            pend_q    <= 1'b0;
            presc_q   <= '0;
            timer_q   <= '0;
        end else begin
            snd_onl_q <= bus.snd_on;
            cmd_q     <= cmd_d;
            int_n_q   <= int_n_d;
            pend_q    <= pend_d;
            presc_q   <= presc_d;
            timer_q   <= timer_d;
        end
    end

`ifdef JTROC_SNDIF_OVERRUN_EN
    logic ovr_q;

    // Sticky overrun: a new command arrived before the previous one was read
    always_ff @(posedge clk) begin
        if (rst)                   ovr_q <= 1'b0;
        else if (on_edge & pend_q) ovr_q <= 1'b1;
    end

    assign ovr_bit = ovr_q;
`else
    assign ovr_bit = 1'b0;
`endif

    generate
        if (SYNC_MUTE != 0) begin : g_mute_sync
            logic [1:0] mute_q;

            // Two-flop synchroniser for the mute request
            always_ff @(posedge clk) begin
                if (rst) mute_q <= '0;
                else     mute_q <= {mute_q[0], bus.mute};
            end

            assign snd_mute_w = mute_q[1];
        end else begin : g_mute_reg
            logic mute_q;

            // Single register stage for the mute request
            always_ff @(posedge clk) begin
                if (rst) mute_q <= 1'b0;
                else     mute_q <= bus.mute;
            end

            assign snd_mute_w = mute_q;
        end
    endgenerate

    assign bus.cmd_dout   = cmd_q;
    assign bus.int_n      = int_n_q;
    assign bus.timer_dout = timer_q;
    assign bus.snd_mute   = snd_mute_w;
    assign bus.st_dout    = {4'd0, ovr_bit, pend_q, snd_mute_w, ~int_n_q};

endmodule
